// File: rtl/hci_tcdm_bank_responder_pkg.sv
// Shared types for the HCI TCDM bank responder.
// Default widths, response bundle and address helper.
package hci_tcdm_bank_responder_pkg;

    localparam int HCI_DW = 32;
    localparam int HCI_AW = 32;
    localparam int HCI_IW = 8;
    localparam int HCI_UW = 1;
    localparam int HCI_EW = 1;

    typedef struct packed {
        logic [HCI_DW-1:0] data;
        logic [HCI_EW-1:0] ecc;
        logic [HCI_IW-1:0] id;
        logic [HCI_UW-1:0] user;
        logic              opc;
    } hci_bank_resp_t;

    localparam int BANK_ADDR_LSB = $clog2(HCI_DW / 8);

    function automatic int bank_addr_lsb(int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/hci_tcdm_bank_responder_if.sv
// HCI core request/response handshake between an initiator and a bank.
// master = initiator side, slave = bank side.
interface hci_tcdm_bank_responder_if #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int IW = 8,
    parameter int UW = 1,
    parameter int EW = 1
);
    logic            req;
    logic            gnt;
    logic [AW-1:0]   add;
    logic            wen;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] be;
    logic [EW-1:0]   ecc;
    logic [IW-1:0]   id;
    logic [UW-1:0]   user;
    logic            r_valid;
    logic            r_ready;
    logic [DW-1:0]   r_data;
    logic [EW-1:0]   r_ecc;
    logic [IW-1:0]   r_id;
    logic [UW-1:0]   r_user;
    logic            r_opc;

    modport master (
        output req, add, wen, data, be, ecc, id, user, r_ready,
        input  gnt, r_valid, r_data, r_ecc, r_id, r_user, r_opc
    );

    modport slave (
        input  req, add, wen, data, be, ecc, id, user, r_ready,
        output gnt, r_valid, r_data, r_ecc, r_id, r_user, r_opc
    );

endinterface

// File: rtl/hci_tcdm_bank_responder_fifo.sv
// Response FIFO for the bank responder: registered storage,
// no fall-through, occupancy exported for credit checking.
module hci_bank_resp_fifo
    import hci_tcdm_bank_responder_pkg::*;
#(
    parameter int  DEPTH = 3,
    parameter type T     = hci_bank_resp_t,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push,
    input  T              din,
    input  logic          pop,
    output T              dout,
    output logic          valid,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    T              buf_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] count_q;

    assign dout  = buf_q[rptr_q];
    assign valid = (count_q != '0);
    assign count = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                buf_q[wptr_q] <= din;
                wptr_q <= (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/hci_tcdm_bank_responder.sv
// One TCDM word bank behind the HCI core handshake, answering every
// accepted request with exactly one in-order response.
module hci_tcdm_bank_responder
    import hci_tcdm_bank_responder_pkg::*;
#(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int IW         = 8,
    parameter int UW         = 1,
    parameter int EW         = 1,
    parameter int N_WORDS    = 1024,
    parameter int FIFO_DEPTH = 3
) (
    input logic clk_i,
    input logic rst_ni,
    input logic clear_i,
    hci_tcdm_bank_responder_if.slave tcdm
);

    localparam int LSB  = bank_addr_lsb(DW);
    localparam int IDXW = $clog2(N_WORDS);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [EW-1:0] ecc;
        logic [IW-1:0] id;
        logic [UW-1:0] user;
        logic          opc;
    } resp_t;

    logic [DW-1:0]   mem_q [N_WORDS];
    logic [EW-1:0]   ecc_q [N_WORDS];
    logic [IDXW-1:0] idx;
    logic            add_unused;
    logic            accept;
    logic            credit_ok;
    logic            inflight_q;
    logic            push;
    logic            pop;
    logic            fifo_valid;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     used;
    resp_t           resp_q;
    resp_t           head;

    assign idx        = tcdm.add[LSB +: IDXW];
    assign add_unused = ^{tcdm.add[AW-1:LSB+IDXW], tcdm.add[LSB-1:0]};

    // Credits cover both stored responses and the one still in the read stage.
    assign used      = {1'b0, fifo_count} + (CW + 1)'(inflight_q);
    assign credit_ok = (used < DEPTH_C);
    assign tcdm.gnt  = tcdm.req & rst_ni & ~clear_i & credit_ok;
    assign accept    = tcdm.req & tcdm.gnt;

    always_ff @(posedge clk_i) begin
        if (accept && !tcdm.wen) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (tcdm.be[b]) mem_q[idx][8*b +: 8] <= tcdm.data[8*b +: 8];
            end
            ecc_q[idx] <= tcdm.ecc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= 1'b0;
            resp_q     <= '0;
        end else begin
            inflight_q <= accept & ~clear_i;
            if (accept) begin
                resp_q.data <= tcdm.wen ? mem_q[idx] : '0;
                resp_q.ecc  <= tcdm.wen ? ecc_q[idx] : '0;
                resp_q.id   <= tcdm.id;
                resp_q.user <= tcdm.user;
                resp_q.opc  <= tcdm.wen;
            end
        end
    end

    assign push = inflight_q & ~clear_i;
    assign pop  = fifo_valid & tcdm.r_ready;

    hci_bank_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (resp_t)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push    (push),
        .din     (resp_q),
        .pop     (pop),
        .dout    (head),
        .valid   (fifo_valid),
        .count   (fifo_count)
    );

    assign tcdm.r_valid = fifo_valid;
    assign tcdm.r_data  = head.data;
    assign tcdm.r_ecc   = head.ecc;
    assign tcdm.r_id    = head.id;
    assign tcdm.r_user  = head.user;
    assign tcdm.r_opc   = head.opc;

endmodule
